// File: rtl/echo_range_detector.sv
// Echo time-of-flight detector: rectifies offset-binary samples about midscale, blanks transmit
// ringing after a burst, then reports the first sustained over-threshold run or a timeout.
module echo_range_detector #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int MIDSCALE         = 32768,
    parameter int THRESHOLD        = 4096,
    parameter int HOLD_COUNT       = 4,
    parameter int BLANKING_SAMPLES = 1000,
    parameter int LISTEN_SAMPLES   = 30000,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    burst_start_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic                    busy_out,
    output logic                    echo_valid_out,
    output logic                    echo_found_out,
    output logic [COUNT_WIDTH-1:0]  tof_samples_out,
    output logic [SAMPLE_WIDTH-1:0] peak_mag_out
);

    localparam logic [SAMPLE_WIDTH-1:0] MID_CODE   = SAMPLE_WIDTH'(MIDSCALE);
    localparam logic [SAMPLE_WIDTH-1:0] THR_MAG    = SAMPLE_WIDTH'(THRESHOLD);
    localparam logic [COUNT_WIDTH-1:0]  HOLD_CNT   = COUNT_WIDTH'(HOLD_COUNT);
    localparam logic [COUNT_WIDTH-1:0]  BLANK_END  =
        COUNT_WIDTH'((BLANKING_SAMPLES > 0) ? BLANKING_SAMPLES - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0]  LISTEN_END =
        COUNT_WIDTH'(BLANKING_SAMPLES + LISTEN_SAMPLES - 1);
    localparam bit                      NO_BLANK   = (BLANKING_SAMPLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam state_t START_STATE = NO_BLANK ? ST_LISTEN : ST_BLANK;

    // |code - MIDSCALE|; the extra sign bit keeps the full-scale negative swing exact.
    function automatic logic [SAMPLE_WIDTH-1:0] rectify(input logic [SAMPLE_WIDTH-1:0] code);
        logic signed [SAMPLE_WIDTH:0] diff;
        logic signed [SAMPLE_WIDTH:0] absd;
        diff = $signed({1'b0, code}) - $signed({1'b0, MID_CODE});
        absd = diff[SAMPLE_WIDTH] ? -diff : diff;
        return absd[SAMPLE_WIDTH-1:0];
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] max_mag(input logic [SAMPLE_WIDTH-1:0] a,
                                                        input logic [SAMPLE_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                   state;
    state_t                   state_next;
    logic [COUNT_WIDTH-1:0]   index_cnt;
    logic [COUNT_WIDTH-1:0]   run_cnt;
    logic [COUNT_WIDTH-1:0]   run_start;
    logic [SAMPLE_WIDTH-1:0]  run_peak;
    logic [SAMPLE_WIDTH-1:0]  win_peak;

    logic                     clear_ctx;
    logic                     blank_step;
    logic                     listen_step;
    logic                     report_found;
    logic                     report_timeout;

    logic                     vld_p0;
    logic [SAMPLE_WIDTH-1:0]  mag_p0;
    logic                     above_p0;
    logic [COUNT_WIDTH-1:0]   run_inc_p0;
    logic                     run_hit_p0;
    logic [COUNT_WIDTH-1:0]   start_p0;
    logic [SAMPLE_WIDTH-1:0]  run_peak_upd_p0;
    logic [SAMPLE_WIDTH-1:0]  win_peak_upd_p0;

    // Stage p0: per-sample magnitude and run bookkeeping, consumed on the accepting edge.
    always_comb begin
        vld_p0          = sample_valid_in;
        mag_p0          = rectify(sample_in);
        above_p0        = (mag_p0 >= THR_MAG);
        run_inc_p0      = run_cnt + COUNT_WIDTH'(1);
        run_hit_p0      = above_p0 && (run_inc_p0 >= HOLD_CNT);
        start_p0        = (run_cnt == '0) ? index_cnt : run_start;
        run_peak_upd_p0 = max_mag(run_peak, mag_p0);
        win_peak_upd_p0 = max_mag(win_peak, mag_p0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_ctx      = 1'b0;
        blank_step     = 1'b0;
        listen_step    = 1'b0;
        report_found   = 1'b0;
        report_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (burst_start_in) begin
                    clear_ctx  = 1'b1;
                    state_next = START_STATE;
                end
            end
            ST_BLANK: begin
                if (burst_start_in) begin
                    clear_ctx  = 1'b1;
                    state_next = START_STATE;
                end else if (vld_p0) begin
                    blank_step = 1'b1;
                    if (index_cnt == BLANK_END) begin
                        state_next = ST_LISTEN;
                    end
                end
            end
            ST_LISTEN: begin
                if (burst_start_in) begin
                    clear_ctx  = 1'b1;
                    state_next = START_STATE;
                end else if (vld_p0) begin
                    listen_step = 1'b1;
                    // A detection on the final window sample takes priority over timeout.
                    if (run_hit_p0) begin
                        report_found = 1'b1;
                        state_next   = ST_REPORT;
                    end else if (index_cnt == LISTEN_END) begin
                        report_timeout = 1'b1;
                        state_next     = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (burst_start_in) begin
                    clear_ctx  = 1'b1;
                    state_next = START_STATE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters are control state and reset; run/window context is cleared on every burst.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            index_cnt <= '0;
            run_cnt   <= '0;
        end else if (clear_ctx) begin
            index_cnt <= '0;
            run_cnt   <= '0;
        end else if (blank_step) begin
            index_cnt <= index_cnt + COUNT_WIDTH'(1);
        end else if (listen_step) begin
            index_cnt <= index_cnt + COUNT_WIDTH'(1);
            run_cnt   <= above_p0 ? run_inc_p0 : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (clear_ctx) begin
            run_start <= '0;
            run_peak  <= '0;
            win_peak  <= '0;
        end else if (listen_step) begin
            win_peak <= win_peak_upd_p0;
            if (above_p0) begin
                run_start <= start_p0;
                run_peak  <= run_peak_upd_p0;
            end else begin
                run_peak  <= '0;
            end
        end
    end

    // Stage p1: result registers, visible in the cycle after the deciding sample is accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            echo_valid_out  <= 1'b0;
            echo_found_out  <= 1'b0;
            tof_samples_out <= '0;
            peak_mag_out    <= '0;
        end else begin
            echo_valid_out <= report_found | report_timeout;
            if (report_found) begin
                echo_found_out  <= 1'b1;
                tof_samples_out <= start_p0;
                peak_mag_out    <= run_peak_upd_p0;
            end else if (report_timeout) begin
                echo_found_out  <= 1'b0;
                tof_samples_out <= '0;
                peak_mag_out    <= win_peak_upd_p0;
            end
        end
    end

    assign busy_out = (state == ST_BLANK) || (state == ST_LISTEN);

endmodule

// File: tb/tb_echo_range_detector.sv
// Bench for echo_range_detector: directed echo scenarios plus randomized bursts scored against
// a window-scan reference model of the detection rules.
module tb_echo_range_detector;

    localparam int SW     = 16;
    localparam int CW     = 16;
    localparam int MID    = 32768;
    localparam int THR    = 4096;
    localparam int HOLD   = 4;
    localparam int BLANK  = 8;
    localparam int LISTEN = 64;
    localparam int LAST   = BLANK + LISTEN - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          burst;
    logic          valid;
    logic [SW-1:0] sample;
    logic          busy;
    logic          echo_valid;
    logic          echo_found;
    logic [CW-1:0] tof;
    logic [SW-1:0] peak;

    int n_tests    = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int exp_pulses = 0;

    echo_range_detector #(
        .SAMPLE_WIDTH    (SW),
        .MIDSCALE        (MID),
        .THRESHOLD       (THR),
        .HOLD_COUNT      (HOLD),
        .BLANKING_SAMPLES(BLANK),
        .LISTEN_SAMPLES  (LISTEN),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .burst_start_in (burst),
        .sample_in      (sample),
        .sample_valid_in(valid),
        .busy_out       (busy),
        .echo_valid_out (echo_valid),
        .echo_found_out (echo_found),
        .tof_samples_out(tof),
        .peak_mag_out   (peak)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (echo_valid) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int v, input int gap);
        repeat (gap) tick();
        valid  = 1'b1;
        sample = SW'(v);
        tick();
        valid  = 1'b0;
    endtask

    // First window of HOLD consecutive above-threshold magnitudes wholly inside LISTEN wins;
    // otherwise a full window yields a timeout carrying the window maximum.
    function automatic void model(input int s[$], output int found, output int tof_e,
                                  output int peak_e, output int decide);
        int mag[$];
        int pk;
        bit all_above;
        foreach (s[i]) mag.push_back((s[i] >= MID) ? s[i] - MID : MID - s[i]);
        found = 0; tof_e = 0; peak_e = 0; decide = -1;
        for (int e = BLANK + HOLD - 1; e < mag.size() && e <= LAST; e++) begin
            all_above = 1'b1;
            pk = 0;
            for (int k = e - HOLD + 1; k <= e; k++) begin
                if (mag[k] < THR) all_above = 1'b0;
                if (mag[k] > pk) pk = mag[k];
            end
            if (all_above) begin
                found = 1; tof_e = e - HOLD + 1; peak_e = pk; decide = e;
                return;
            end
        end
        if (mag.size() > LAST) begin
            decide = LAST;
            for (int k = BLANK; k <= LAST; k++) if (mag[k] > peak_e) peak_e = mag[k];
        end
    endfunction

    // Returns in the report cycle when a decision is expected, so a following call can
    // land its burst_start on the REPORT state.
    task automatic run_burst(input string tag, input int s[$], input bit rand_gaps,
                             input bit valid_with_burst);
        int found_e, tof_e, peak_e, decide, base, gap;
        bit early;
        model(s, found_e, tof_e, peak_e, decide);
        base  = pulse_cnt;
        early = 1'b0;
        burst  = 1'b1;
        valid  = valid_with_burst;
        sample = '0;
        tick();
        burst = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            gap = rand_gaps ? int'($urandom_range(0, 5)) : 3;
            repeat (gap) begin
                tick();
                if (echo_valid) early = 1'b1;
            end
            valid  = 1'b1;
            sample = SW'(s[i]);
            tick();
            valid  = 1'b0;
            if (i == decide) begin
                check({tag, "_valid"}, echo_valid, 1);
                check({tag, "_found"}, echo_found, found_e);
                check({tag, "_tof"}, tof, tof_e);
                check({tag, "_peak"}, peak, peak_e);
                check({tag, "_busy_rep"}, busy, 0);
                break;
            end else if (echo_valid) begin
                early = 1'b1;
            end
        end
        check({tag, "_no_early"}, early, 0);
        if (decide >= 0) begin
            exp_pulses++;
            @(negedge clk);
            #1;
            check({tag, "_pulses"}, pulse_cnt - base, 1);
        end else begin
            check({tag, "_pulses"}, pulse_cnt - base, 0);
            check({tag, "_busy"}, busy, 1);
        end
    endtask

    int q[$];
    int base;
    int blob;

    initial begin
        rst = 1'b1; burst = 1'b0; valid = 1'b0; sample = SW'(MID);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", echo_valid, 0);
        check("rst_found", echo_found, 0);
        check("rst_tof", tof, 0);
        check("rst_peak", peak, 0);

        // Echo straddling blanking is ignored; later echo detected.
        q = {};
        for (int i = 0; i < 24; i++) q.push_back(i < 8 ? 40000 : (i < 20 ? 32768 : 40768));
        run_burst("s2", q, 1'b0, 1'b0);
        check("s2_found_k", echo_found, 1);
        check("s2_tof_k", tof, 20);
        check("s2_peak_k", peak, 8000);
        repeat (5) tick();

        // Reset mid-LISTEN aborts and clears held results.
        base = pulse_cnt;
        burst = 1'b1;
        tick();
        burst = 1'b0;
        for (int i = 0; i < 20; i++) send_sample(MID, 3);
        check("s1_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        tick();
        check("s1_busy", busy, 0);
        check("s1_valid", echo_valid, 0);
        check("s1_found", echo_found, 0);
        check("s1_tof", tof, 0);
        check("s1_peak", peak, 0);
        rst = 1'b0;
        for (int i = 0; i < 70; i++) send_sample(MID, 3);
        check("s1_no_pulse", pulse_cnt - base, 0);
        check("s1_busy_post", busy, 0);

        // Broken run is not reported.
        q = {};
        for (int i = 0; i < 72; i++) q.push_back(MID);
        q[30] = 37000; q[31] = 37000; q[32] = 37000;
        q[40] = 38000; q[41] = 26768; q[42] = 41000; q[43] = 37000;
        run_burst("s3", q, 1'b0, 1'b0);
        check("s3_found_k", echo_found, 1);
        check("s3_tof_k", tof, 40);
        check("s3_peak_k", peak, 8232);
        repeat (4) tick();

        // Timeout with a single spike.
        q = {};
        for (int i = 0; i < 72; i++) q.push_back(MID);
        q[50] = 37768;
        run_burst("s4", q, 1'b0, 1'b0);
        check("s4_found_k", echo_found, 0);
        check("s4_tof_k", tof, 0);
        check("s4_peak_k", peak, 5000);
        repeat (4) tick();

        // Restart mid-LISTEN: first burst never reports.
        q = {};
        for (int i = 0; i < 30; i++) q.push_back(MID);
        run_burst("s5a", q, 1'b0, 1'b0);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(i >= 12 ? 40000 : MID);
        run_burst("s5b", q, 1'b0, 1'b0);
        check("s5_tof_k", tof, 12);

        // Burst during REPORT, full-scale negative samples, random gaps.
        q = {};
        for (int i = 0; i < 20; i++) q.push_back((i >= 10 && i <= 13) ? 0 : MID);
        run_burst("s6a", q, 1'b1, 1'b0);
        check("s6a_peak_k", peak, 32768);
        repeat (4) tick();
        // Valid sample coincident with burst in IDLE must not be indexed.
        run_burst("s6b", q, 1'b1, 1'b1);
        check("s6b_tof_k", tof, 10);
        repeat (3) tick();

        for (int b = 0; b < 14; b++) begin
            q = {};
            blob = 0;
            for (int i = 0; i < 72; i++) begin
                if (blob == 0 && $urandom_range(0, 9) == 0) blob = int'($urandom_range(1, 6));
                if (blob > 0) begin
                    blob--;
                    q.push_back(int'($urandom_range(0, 65535)));
                end else begin
                    q.push_back(MID + int'($urandom_range(0, 4000)) - 2000);
                end
            end
            run_burst($sformatf("rnd%0d", b), q, 1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 6))) tick();
        end

        repeat (10) tick();
        check("total_pulses", pulse_cnt, exp_pulses);
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
